apb_initiator: RTL and testbench

APB_INITIATOR -- requirements
Module: apb_initiator

---
 rtl/apb_initiator.sv | 75 +++++++
 tb/tb_apb_initiator.sv | 134 +++++++++++++
 2 files changed

// File: rtl/apb_initiator.sv
// apb_initiator: command-to-APB bridge sequencing IDLE/SETUP/ACCESS with registered outputs.
// Optional ACCESS-phase timeout is compiled in by defining APB_INITIATOR_TIMEOUT_EN.
module apb_initiator #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        pClk,
    input  logic        pReset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        pSel,
    output logic        pEnable,
    output logic        pWrite,
    output logic [31:0] pAddr,
    output logic [31:0] pWdata,
    input  logic [31:0] pReadData,
    input  logic        pReady
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
    state_t state, nextState;
    logic accept, done, timedOut;
    assign accept = cmd_valid && cmd_ready;
`ifdef APB_INITIATOR_TIMEOUT_EN
    logic [7:0] waitCnt;
    // Abort on the last permitted low-pReady cycle so pEnable stays high for exactly TIMEOUT_CYCLES.
    assign timedOut = state == ACCESS && !pReady && waitCnt == 8'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge pClk) begin
        if (pReset) waitCnt <= '0;
        else if (state == SETUP) waitCnt <= '0;
        else if (state == ACCESS && !pReady) waitCnt <= waitCnt + 8'd1;
    end
`else
    logic unusedTimeout;
    assign unusedTimeout = TIMEOUT_CYCLES != 0;
    assign timedOut = 1'b0;
`endif
    assign done = state == ACCESS && (pReady || timedOut);
    always_comb begin
        nextState = state == IDLE ? (accept ? SETUP : IDLE) : state == SETUP ? ACCESS : done ? IDLE : ACCESS;
    end
    always_ff @(posedge pClk) begin
        if (pReset) state <= IDLE;
        else state <= nextState;
    end
    always_ff @(posedge pClk) begin
        if (pReset) begin
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            pSel      <= 1'b0;
            pEnable   <= 1'b0;
            pWrite    <= 1'b0;
            pAddr     <= '0;
            pWdata    <= '0;
        end else begin
            cmd_ready <= nextState == IDLE;
            pSel      <= nextState != IDLE;
            pEnable   <= nextState == ACCESS;
            rsp_valid <= done;
            rsp_err   <= timedOut;
            if (done) rsp_rdata <= (pWrite || timedOut) ? '0 : pReadData;
            if (accept) begin
                pWrite <= cmd_write;
                pAddr  <= cmd_addr;
                pWdata <= cmd_wdata;
            end
        end
    end
endmodule

// File: tb/tb_apb_initiator.sv
// tb_apb_initiator: directed plus randomized transfers checked against a transaction-level model.
module tb_apb_initiator;
    localparam int TO = 16;
`ifdef APB_INITIATOR_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif
    logic pClk = 1'b0, pReset = 1'b1;
    logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic pSel, pEnable, pWrite;
    logic [31:0] pAddr, pWdata;
    logic [31:0] pReadData = '0;
    logic pReady = 1'b0;
    int tests = 0, fails = 0;

    apb_initiator #(.TIMEOUT_CYCLES(TO)) dut (
        .pClk(pClk), .pReset(pReset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .pSel(pSel), .pEnable(pEnable), .pWrite(pWrite), .pAddr(pAddr), .pWdata(pWdata),
        .pReadData(pReadData), .pReady(pReady)
    );

    always #5 pClk = ~pClk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One transfer: called at a negedge, returns at the negedge of the response cycle.
    task automatic runTxn(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] rd, input int waits, input bit holdValid);
        int expEn = (TMO && waits >= TO) ? TO : waits + 1;
        bit expErr = TMO && waits >= TO;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        pReadData = rd; pReady = 1'b0;
        chk("acceptReady", {31'd0, cmd_ready}, 32'd1);
        @(negedge pClk);
        if (!holdValid) cmd_valid = 1'b0;
        cmd_addr = 32'hFFFFFFFF; cmd_wdata = ~d; cmd_write = ~w;
        chk("setupSel", {31'd0, pSel}, 32'd1);
        chk("setupEn", {31'd0, pEnable}, 32'd0);
        chk("setupAddr", pAddr, a);
        chk("setupWrite", {31'd0, pWrite}, {31'd0, w});
        chk("setupWdata", pWdata, d);
        chk("setupNoRsp", {31'd0, rsp_valid}, 32'd0);
        chk("setupBusy", {31'd0, cmd_ready}, 32'd0);
        for (int k = 1; k <= expEn; k++) begin
            @(negedge pClk);
            pReady = k > waits;
            chk("accessSelEn", {30'd0, pSel, pEnable}, 32'd3);
            chk("accessAddr", pAddr, a);
            chk("accessWdata", pWdata, d);
            chk("accessNoRsp", {31'd0, rsp_valid}, 32'd0);
        end
        @(negedge pClk);
        pReady = 1'b0;
        chk("rspValid", {31'd0, rsp_valid}, 32'd1);
        chk("rspErr", {31'd0, rsp_err}, {31'd0, expErr});
        chk("rspRdata", rsp_rdata, (w || expErr) ? 32'd0 : rd);
        chk("rspSelEn", {30'd0, pSel, pEnable}, 32'd0);
        chk("rspReady", {31'd0, cmd_ready}, 32'd1);
        chk("rspAddrHeld", pAddr, a);
    endtask

    initial begin
        logic [31:0] lastAddr;
        repeat (2) @(negedge pClk);
        chk("rstReady", {31'd0, cmd_ready}, 32'd0);
        chk("rstRsp", {30'd0, rsp_valid, rsp_err}, 32'd0);
        chk("rstRdata", rsp_rdata, 32'd0);
        chk("rstApb", {29'd0, pSel, pEnable, pWrite}, 32'd0);
        chk("rstAddr", pAddr, 32'd0);
        chk("rstWdata", pWdata, 32'd0);
        pReset = 1'b0;
        @(negedge pClk);
        chk("relReady", {31'd0, cmd_ready}, 32'd1);

        runTxn(1'b1, 32'h4, 32'hA5, 32'h0, 0, 1'b0);
        @(negedge pClk);
        chk("pulseOnce", {31'd0, rsp_valid}, 32'd0);
        runTxn(1'b0, 32'h8, 32'h0, 32'h5A, 3, 1'b0);
        runTxn(1'b1, 32'h10, 32'h1234, 32'h0, 0, 1'b1);
        runTxn(1'b0, 32'h14, 32'h0, 32'hCAFE, 1, 1'b1);
        cmd_valid = 1'b0;
        @(negedge pClk);
        chk("b2bPulseOnce", {31'd0, rsp_valid}, 32'd0);
        chk("idleAddrHeld", pAddr, 32'h14);

        for (int i = 0; i < 24; i++) begin
            logic [31:0] a = $urandom & 32'hFFFC;
            runTxn(1'($urandom), a, $urandom, $urandom, int'($urandom_range(0, 20)), 1'($urandom));
            lastAddr = a;
            cmd_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                @(negedge pClk);
                chk("gapIdle", {29'd0, pSel, pEnable, rsp_valid}, 32'd0);
                chk("gapReady", {31'd0, cmd_ready}, 32'd1);
                chk("gapAddrHeld", pAddr, lastAddr);
            end
        end
        if (TMO) begin
            runTxn(1'b0, 32'h20, 32'h0, 32'h77, TO + 4, 1'b0);
            runTxn(1'b0, 32'h24, 32'h0, 32'h66, TO - 1, 1'b0);
        end else begin
            runTxn(1'b0, 32'h20, 32'h0, 32'h77, TO + 4, 1'b0);
        end

        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h30; pReady = 1'b0;
        repeat (3) @(negedge pClk);
        cmd_valid = 1'b0;
        chk("midAccess", {30'd0, pSel, pEnable}, 32'd3);
        pReset = 1'b1;
        @(negedge pClk);
        pReset = 1'b0; pReady = 1'b1;
        chk("midRstApb", {29'd0, pSel, pEnable, rsp_valid}, 32'd0);
        @(negedge pClk);
        chk("midRelReady", {31'd0, cmd_ready}, 32'd1);
        chk("midNoRsp", {31'd0, rsp_valid}, 32'd0);
        @(negedge pClk);
        chk("midStillIdle", {29'd0, pSel, pEnable, rsp_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
